// File: rtl/led_pkg.sv
// led_pkg: LED mode encoding, 50 MHz default half-periods and mode successor helper
package led_pkg;
  typedef enum logic [1:0] {
    MODE_OFF        = 2'd0,
    MODE_ON         = 2'd1,
    MODE_BLINK_SLOW = 2'd2,
    MODE_BLINK_FAST = 2'd3
  } led_mode_t;
  localparam int DEFAULT_SLOW_HALF_PERIOD = 25_000_000;
  localparam int DEFAULT_FAST_HALF_PERIOD = 6_250_000;
  function automatic led_mode_t next_mode_of(input led_mode_t m);
    return m == MODE_OFF ? MODE_ON :
           m == MODE_ON ? MODE_BLINK_SLOW :
           m == MODE_BLINK_SLOW ? MODE_BLINK_FAST : MODE_OFF;
  endfunction
endpackage

// File: rtl/blink_timer.sv
// blink_timer: phase counter (clock, reset, clear, run, half_period) pulsing toggle_tick when it wraps at half_period-1
module blink_timer #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         run,
  input  logic [W-1:0] half_period,
  output logic         toggle_tick
);
  logic [W-1:0] count;
  assign toggle_tick = run && !clear && count == half_period - W'(1);
  always_ff @(posedge clock or posedge reset)
    if (reset) count <= '0;
    else count <= (clear || !run || toggle_tick) ? '0 : count + W'(1);
endmodule

// File: rtl/led_mode_driver.sv
// led_mode_driver: next_mode pulses cycle off/on/slow/fast blink, force_off overrides (clock, reset, next_mode, force_off -> mode, led)
module led_mode_driver
  import led_pkg::*;
#(
  parameter int SLOW_HALF_PERIOD = DEFAULT_SLOW_HALF_PERIOD,
  parameter int FAST_HALF_PERIOD = DEFAULT_FAST_HALF_PERIOD
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       next_mode,
  input  logic       force_off,
  output logic [1:0] mode,
  output logic       led
);
  localparam int W = $clog2(SLOW_HALF_PERIOD + 1);
  led_mode_t mode_q, mode_d;
  logic led_q, led_d, clear, blink, toggle_tick;
  logic [W-1:0] half_period;
  blink_timer #(.W(W)) u_timer (
    .clock(clock),
    .reset(reset),
    .clear(clear),
    .run(blink),
    .half_period(half_period),
    .toggle_tick(toggle_tick)
  );
  always_comb begin
    blink = mode_q == MODE_BLINK_SLOW || mode_q == MODE_BLINK_FAST;
    half_period = mode_q == MODE_BLINK_FAST ? W'(FAST_HALF_PERIOD) : W'(SLOW_HALF_PERIOD);
    clear = force_off || next_mode;
    mode_d = force_off ? MODE_OFF : next_mode ? next_mode_of(mode_q) : mode_q;
    led_d = clear ? mode_d != MODE_OFF : blink ? led_q ^ toggle_tick : mode_q == MODE_ON;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      mode_q <= MODE_OFF;
      led_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      led_q <= led_d;
    end
  assign mode = mode_q;
  assign led = led_q;
endmodule

// File: tb/tb_led_mode_driver.sv
// tb_led_mode_driver: randomized and directed checks of led_mode_driver against a time-in-mode reference model
module tb_led_mode_driver;
  logic clock = 0, reset = 1, next_mode = 0, force_off = 0;
  logic [1:0] mode;
  logic led;
  int total = 0, bad = 0;
  int m_mode = 0, m_age = 0;
  bit go = 0;

  led_mode_driver #(.SLOW_HALF_PERIOD(8), .FAST_HALF_PERIOD(2)) dut (
    .clock(clock),
    .reset(reset),
    .next_mode(next_mode),
    .force_off(force_off),
    .mode(mode),
    .led(led)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock or posedge reset)
    if (reset) begin
      m_mode = 0;
      m_age = 0;
    end else if (force_off) begin
      m_mode = 0;
      m_age = 0;
    end else if (next_mode) begin
      m_mode = (m_mode + 1) % 4;
      m_age = 0;
    end else m_age++;

  function automatic int model_led();
    return int'(m_mode == 1 || (m_mode == 2 && (m_age / 8) % 2 == 0) ||
                (m_mode == 3 && (m_age / 2) % 2 == 0));
  endfunction

  always @(negedge clock)
    if (go) begin
      check("model_mode", int'(mode), m_mode);
      check("model_led", int'(led), model_led());
    end

  task automatic pulse();
    @(posedge clock); #1 next_mode = 1;
    @(posedge clock); #1 next_mode = 0;
  endtask

  initial begin
    logic [31:0] slow_pat;
    logic [15:0] fast_pat;
    slow_pat = 32'hFF00FF00;
    fast_pat = 16'hCCCC;
    repeat (3) @(posedge clock);
    #1 reset = 0;
    go = 1;
    repeat (20) @(posedge clock);
    #1 check("idle_mode", int'(mode), 0);
    check("idle_led", int'(led), 0);
    for (int i = 0; i < 4; i++) begin
      pulse();
      check("step_mode", int'(mode), (i + 1) % 4);
      check("step_led", int'(led), i < 3 ? 1 : 0);
      if (i == 1)
        for (int j = 0; j < 32; j++) begin
          @(negedge clock);
          check("slow_pattern", int'(led), int'(slow_pat[31-j]));
        end
      repeat (29) @(posedge clock);
    end
    @(posedge clock); #1 next_mode = 1;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clock); #1 check("held_mode", int'(mode), i);
    end
    next_mode = 0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clock);
      check("fast_pattern", int'(led), int'(fast_pat[15-j]));
    end
    pulse();
    pulse();
    check("on_mode", int'(mode), 1);
    @(posedge clock); #1 next_mode = 1; force_off = 1;
    @(posedge clock); #1 next_mode = 0; force_off = 0;
    check("force_mode", int'(mode), 0);
    check("force_led", int'(led), 0);
    pulse();
    pulse();
    repeat (7) @(posedge clock);
    #1 next_mode = 1;
    @(posedge clock); #1 next_mode = 0;
    check("wrap_pulse_mode", int'(mode), 3);
    check("wrap_pulse_led", int'(led), 1);
    repeat (2) @(posedge clock);
    #1 check("wrap_pulse_phase", int'(led), 0);
    pulse();
    pulse();
    pulse();
    check("slow_entry", int'(mode), 2);
    repeat (5) @(posedge clock);
    #3 reset = 1;
    #1 check("async_reset_led", int'(led), 0);
    check("async_reset_mode", int'(mode), 0);
    @(posedge clock); #1 reset = 0;
    repeat (4) @(posedge clock);
    #1 check("post_reset_led", int'(led), 0);
    pulse();
    check("post_reset_mode", int'(mode), 1);
    for (int i = 0; i < 600; i++) begin
      @(posedge clock);
      #1;
      if (reset) reset = 0;
      else if ($urandom_range(199) == 0) begin
        #2 reset = 1;
      end
      next_mode = $urandom_range(7) == 0;
      force_off = $urandom_range(31) == 0;
    end
    @(posedge clock); #1 next_mode = 0; force_off = 0; reset = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
